// File: rtl/amp_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encoding, the latched request payload and small funct3 decode helpers.
// Optional build macro LSU_MISALIGN_TRAP_EN is consumed by load_store_unit.
package amp_pkg;

    localparam int unsigned DW = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        WAIT   = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } lsu_state_t;

    // Request fields held for the life of one access
    typedef struct packed {
        logic          we;
        logic [2:0]    funct3;
        logic [1:0]    off;
        logic [DW-1:0] wdata;
    } lsu_req_t;

    // Stores only have the B/H/W encodings; unsigned variants are load-only
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return |off;
            default: return 1'b0;
        endcase
    endfunction

    // Clear the low address bits to the natural alignment of the access size
    function automatic logic [1:0] f3_align(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return {off[1], 1'b0};
            2'b10:   return 2'b00;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//  funct3      : RV32I load/store size/sign code
//  off         : byte offset within the word (already aligned to access size)
//  word        : word read from DMEM
//  wdata       : store data (low bits used for SB/SH)
//  load_data_c : extracted and sign/zero-extended load result
//  merged_c    : word with the addressed byte/half replaced by store data
module lsu_align
    import amp_pkg::*;
(
    input  logic [2:0]    funct3,
    input  logic [1:0]    off,
    input  logic [DW-1:0] word,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] load_data_c,
    output logic [DW-1:0] merged_c
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Little-endian lane select
    always_comb begin
        lane_b = word[7:0];
        case (off)
            2'd0: lane_b = word[7:0];
            2'd1: lane_b = word[15:8];
            2'd2: lane_b = word[23:16];
            2'd3: lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        lane_h = off[1] ? word[31:16] : word[15:0];
    end

    // Load extension
    always_comb begin
        load_data_c = '0;
        case (funct3)
            F3_B:    load_data_c = {{24{lane_b[7]}}, lane_b};
            F3_H:    load_data_c = {{16{lane_h[15]}}, lane_h};
            F3_W:    load_data_c = word;
            F3_BU:   load_data_c = {24'd0, lane_b};
            F3_HU:   load_data_c = {16'd0, lane_h};
            default: load_data_c = '0;
        endcase
    end

    // Store merge: untouched lanes keep the memory value
    always_comb begin
        merged_c = word;
        case (funct3[1:0])
            2'b00: begin
                case (off)
                    2'd0: merged_c[7:0]   = wdata[7:0];
                    2'd1: merged_c[15:8]  = wdata[7:0];
                    2'd2: merged_c[23:16] = wdata[7:0];
                    2'd3: merged_c[31:24] = wdata[7:0];
                    default: merged_c = word;
                endcase
            end
            2'b01: begin
                if (off[1]) merged_c[31:16] = wdata[15:0];
                else        merged_c[15:0]  = wdata[15:0];
            end
            default: merged_c = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the multicycle core and a word-wide, sync-read DMEM.
// Converts RV32I byte/half/word loads and stores into word accesses; sub-word
// stores use read-modify-write. Illegal funct3 (and, with LSU_MISALIGN_TRAP_EN
// defined, misaligned H/W accesses) complete with rsp_err and no DMEM access.
// Without LSU_MISALIGN_TRAP_EN, misaligned addresses are forced to alignment.
//  clk, reset            : clock, synchronous active-high reset
//  req_valid/req_ready   : request handshake (ready only while idle)
//  req_we/funct3/addr/wdata : request payload
//  rsp_valid/rdata/err   : one-cycle completion pulse with result
//  mem_addr/we/wdata     : DMEM word address, write enable, write data
//  mem_rdata             : DMEM read data, one cycle after mem_addr
module load_store_unit
    import amp_pkg::*;
#(
    parameter int unsigned AW    = 10,
    parameter int unsigned WIDTH = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    lsu_state_t       state_q, state_d;
    lsu_req_t         req_q, req_d;
    logic             req_err_c;
    logic             ready_d, rsp_valid_d, rsp_err_d, mem_we_q, mem_we_d;
    logic [WIDTH-1:0] rsp_rdata_d, mem_wdata_d;
    logic [AW-1:0]    mem_addr_d;
    logic [DW-1:0]    load_data_c, merged_c;

    // Upper address bits wrap within DMEM
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    lsu_align u_align (
        .funct3      (req_q.funct3),
        .off         (req_q.off),
        .word        (mem_rdata),
        .wdata       (req_q.wdata),
        .load_data_c (load_data_c),
        .merged_c    (merged_c)
    );

    // Requests that complete immediately with an error
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        req_err_c = !f3_legal(req_we, req_funct3) ||
                    f3_misaligned(req_funct3, req_addr[1:0]);
`else
        req_err_c = !f3_legal(req_we, req_funct3);
`endif
    end

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        mem_addr_d  = mem_addr;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    ready_d      = 1'b0;
                    req_d.we     = req_we;
                    req_d.funct3 = req_funct3;
                    req_d.off    = f3_align(req_funct3, req_addr[1:0]);
                    req_d.wdata  = req_wdata;
                    if (req_err_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = ACCESS;
                        mem_addr_d = req_addr[AW+1:2];
                        // Full-word stores write straight away, no read needed
                        if (req_we && req_funct3 == F3_W) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata;
                        end
                    end
                end
            end
            ACCESS: begin
                if (req_q.we && req_q.funct3 == F3_W) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (req_q.we) begin
                    state_d     = WRITE;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merged_c;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data_c;
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_addr  <= '0;
            mem_we_q  <= 1'b0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            req_ready <= ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            mem_addr  <= mem_addr_d;
            mem_we_q  <= mem_we_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // Suppress a pending write in the very cycle reset arrives
    assign mem_we = mem_we_q & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// requests checked against an arithmetic reference model of memory.
module tb_load_store_unit;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    int we_total = 0;
    int rsp_total = 0;

    logic [31:0]   mem     [0:DEPTH-1];
    logic [31:0]   ref_mem [0:DEPTH-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_idx = '0;
    logic [31:0]   pl_data = '0;

    always #5 clk = ~clk;

    load_store_unit #(.AW(AW), .WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Sync-read DMEM with a bench preload port
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_we) we_total <= we_total + 1;
        if (rsp_valid) rsp_total <= rsp_total + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic poke(input int unsigned idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = AW'(idx); pl_data = val;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Reference: result, error, latency and write count of one request
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd,
                         output logic err, output int lat, output int wes);
        int unsigned size, boff, idx;
        bit sgn, legal, mis;
        logic [31:0] mask, v;
        size = 0; sgn = 0;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: begin size = 4; sgn = 0; end
            3'd4: begin size = 1; sgn = 0; end
            3'd5: begin size = 2; sgn = 0; end
            default: size = 0;
        endcase
        legal = (size != 0) && !(we && f3 > 3'd2);
        idx  = (addr >> 2) % DEPTH;
        boff = addr % 4;
        mis  = legal && (boff % size) != 0;
        rd = 32'd0; wes = 0; lat = 1;
`ifdef LSU_MISALIGN_TRAP_EN
        err = !legal || mis;
`else
        err = !legal;
        if (legal) boff = boff - (boff % size);
`endif
        if (!err) begin
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            if (we) begin
                ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * boff))) |
                               ((wdata & mask) << (8 * boff));
                wes = 1;
                lat = (size == 4) ? 2 : 4;
            end else begin
                v = (ref_mem[idx] >> (8 * boff)) & mask;
                if (sgn && v > (mask >> 1)) v = v - (mask + 32'd1);
                rd  = v;
                lat = 3;
            end
        end
    endtask

    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] got);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat, exp_wes, lat, we0, n;
        model(we, f3, addr, wdata, exp_rd, exp_err, exp_lat, exp_wes);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        we0 = we_total;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        // Scramble the bus so only latched values can produce the right answer
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, " rsp_rdata"}, rsp_rdata, exp_rd);
        got = rsp_rdata;
        @(posedge clk); #1;
        check({tag, " pulse"}, 32'(rsp_valid), 32'd0);
        check({tag, " ready_after"}, 32'(req_ready), 32'd1);
        check({tag, " mem_we_count"}, 32'(we_total - we0), 32'(exp_wes));
    endtask

    initial begin
        logic [31:0] got, a;
        int rsp0, we0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) poke(i, $urandom);

        // T1: signed byte load
        poke(1, 32'h8899AABB);
        run_req("T1 LB", 1'b0, 3'd0, 32'h6, 32'h0, got);
        check("T1 value", got, 32'hFFFFFF99);

        // T2: byte store read-modify-write
        run_req("T2 SB", 1'b1, 3'd0, 32'h5, 32'h12, got);
        check("T2 mem1", mem[1], 32'h889912BB);

        // T3: word store then unsigned half load
        run_req("T3 SW", 1'b1, 3'd2, 32'h8, 32'hDEADBEEF, got);
        check("T3 mem2", mem[2], 32'hDEADBEEF);
        run_req("T3 LHU", 1'b0, 3'd5, 32'hA, 32'h0, got);
        check("T3 value", got, 32'h0000DEAD);

        // T4: illegal load funct3
        run_req("T4 illegal", 1'b0, 3'd3, 32'h4, 32'h0, got);
        run_req("T4 illegal store", 1'b1, 3'd4, 32'h4, 32'h55, got);

        // T5: misaligned word load
        poke(0, 32'h01234567);
        run_req("T5 LW", 1'b0, 3'd2, 32'h2, 32'h0, got);
`ifndef LSU_MISALIGN_TRAP_EN
        check("T5 value", got, 32'h01234567);
`endif
        run_req("T5 SH", 1'b1, 3'd1, 32'h3, 32'hA5A5, got);

        // T6: reset while an SH waits for read data
        poke(3, 32'hCAFEF00D);
        @(negedge clk);
        rsp0 = rsp_total; we0 = we_total;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'hE; req_wdata = 32'h5555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("T6 no rsp_valid", 32'(rsp_total - rsp0), 32'd0);
        check("T6 no mem_we", 32'(we_total - we0), 32'd0);
        check("T6 mem3", mem[3], 32'hCAFEF00D);
        check("T6 req_ready", 32'(req_ready), 32'd1);

        // Randomized traffic, with address bits above the DMEM range set
        for (int i = 0; i < 80; i++) begin
            a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255));
            run_req("rand", 1'($urandom), 3'($urandom), a, $urandom, got);
        end

        for (int i = 0; i < 64; i++) check("final mem", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
